// File: rtl/pbit_sweep_scheduler.sv
// Gibbs sweep sequencer for a fused p-bit network: one-hot update strobes, settle gaps,
// per-sweep state capture and a saturating bit_shift anneal ramp.
module pbit_sweep_scheduler #(
  parameter int unsigned N_BITS  = 5,
  parameter int unsigned SWEEP_W = 16,
  parameter int unsigned SETTLE  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [SWEEP_W-1:0] num_sweeps_i,
  input  logic [SWEEP_W-1:0] anneal_step_i,
  input  logic [N_BITS-1:0]  bit_sample_i,
  output logic [N_BITS-1:0]  update_en_o,
  output logic [1:0]         bit_shift_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_BITS-1:0]  sample_o,
  output logic               sample_valid_o,
  output logic [SWEEP_W-1:0] sweep_count_o
);

  localparam int unsigned IdxW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_BITS - 1);
  localparam logic [SetW-1:0] SetLast = SetW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {StIdle, StUpdate, StSettle, StCapture, StDone} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic [SetW-1:0]    settle_q;
  logic [SWEEP_W-1:0] num_q;
  logic [SWEEP_W-1:0] step_q;
  logic [SWEEP_W-1:0] anneal_q;
  logic [N_BITS-1:0]  update_en_q;
  logic [1:0]         bit_shift_q;
  logic               busy_q;
  logic               done_q;
  logic [N_BITS-1:0]  sample_q;
  logic               sample_valid_q;
  logic [SWEEP_W-1:0] sweep_count_q;
  logic               bit_end;

  // Last cycle spent on the current bit; with no settle gap that is the strobe cycle itself.
  always_comb begin
    bit_end = ((state_q == StUpdate) && (SETTLE == 0)) ||
              ((state_q == StSettle) && (settle_q == SetLast));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      settle_q       <= '0;
      num_q          <= '0;
      step_q         <= '0;
      anneal_q       <= '0;
      update_en_q    <= '0;
      bit_shift_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sweep_count_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i && !abort_i) begin
            num_q         <= num_sweeps_i;
            step_q        <= anneal_step_i;
            idx_q         <= '0;
            sweep_count_q <= '0;
            anneal_q      <= '0;
            bit_shift_q   <= '0;
            if (num_sweeps_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q     <= StUpdate;
              update_en_q <= N_BITS'(1);
              busy_q      <= 1'b1;
            end
          end
        end
        StUpdate: begin
          update_en_q <= '0;
          if (SETTLE != 0) begin
            state_q  <= StSettle;
            settle_q <= '0;
          end
        end
        StSettle: settle_q <= settle_q + 1'b1;
        StCapture: begin
          sample_valid_q <= 1'b0;
          if (sweep_count_q == num_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= StUpdate;
            idx_q       <= '0;
            update_en_q <= N_BITS'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (bit_end) begin
        if (idx_q == IdxLast) begin
          state_q        <= StCapture;
          sample_q       <= bit_sample_i;
          sample_valid_q <= 1'b1;
          sweep_count_q  <= sweep_count_q + 1'b1;
          if (step_q != '0) begin
            if (anneal_q + 1'b1 == step_q) begin
              anneal_q <= '0;
              if (bit_shift_q != 2'd3) bit_shift_q <= bit_shift_q + 2'd1;
            end else begin
              anneal_q <= anneal_q + 1'b1;
            end
          end
        end else begin
          state_q     <= StUpdate;
          idx_q       <= idx_q + 1'b1;
          update_en_q <= N_BITS'(1) << (idx_q + 1'b1);
        end
      end

      // Abort wins over everything above; captured results are left intact.
      if (abort_i && (state_q != StIdle)) begin
        state_q        <= StIdle;
        update_en_q    <= '0;
        busy_q         <= 1'b0;
        done_q         <= 1'b0;
        sample_valid_q <= 1'b0;
      end
    end
  end

  assign update_en_o    = update_en_q;
  assign bit_shift_o    = bit_shift_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign sweep_count_o  = sweep_count_q;

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Directed bench for pbit_sweep_scheduler (N_BITS=5, SETTLE=2, sweep length 16 cycles).
module tb_pbit_sweep_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_sweeps = '0;
  logic [15:0] anneal_step = '0;
  logic [4:0]  bit_sample = '0;
  logic [4:0]  update_en;
  logic [1:0]  bit_shift;
  logic        busy;
  logic        done;
  logic [4:0]  sample;
  logic        sample_valid;
  logic [15:0] sweep_count;

  int errors = 0;
  int checks = 0;

  pbit_sweep_scheduler #(.N_BITS(5), .SWEEP_W(16), .SETTLE(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .abort_i        (abort),
    .num_sweeps_i   (num_sweeps),
    .anneal_step_i  (anneal_step),
    .bit_sample_i   (bit_sample),
    .update_en_o    (update_en),
    .bit_shift_o    (bit_shift),
    .busy_o         (busy),
    .done_o         (done),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .sweep_count_o  (sweep_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int         num;
    int         step;
    logic [4:0] bits;
    int         extra_start;
    int         exp_shift;
    int         exp_count;
    logic [4:0] exp_sample;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int shift_after(input int sweeps, input int step);
    int s;
    if (step == 0) return 0;
    s = sweeps / step;
    return (s > 3) ? 3 : s;
  endfunction

  // Cycle c=1 is the cycle right after the edge that samples start.
  task automatic run_vec(input vec_t v);
    int run_len = v.num * 16;
    num_sweeps  = 16'(v.num);
    anneal_step = 16'(v.step);
    bit_sample  = v.bits;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= run_len + 2; c++) begin
      int         pos = (c - 1) % 16;
      int         k = (c - 1) / 16 + 1;
      logic       in_run = (c <= run_len);
      logic [4:0] exp_en = (in_run && (pos % 3 == 0) && (pos < 15)) ? 5'(1 << (pos / 3)) : 5'd0;
      chk("update_en", int'(update_en), int'(exp_en));
      chk("busy", int'(busy), int'(in_run));
      chk("done", int'(done), int'(c == run_len + 1));
      chk("sample_valid", int'(sample_valid), int'(in_run && pos == 15));
      if (in_run && pos == 15) chk("sample", int'(sample), int'(v.bits));
      if (exp_en != 0) begin
        chk("bit_shift_in_sweep", int'(bit_shift), shift_after(k - 1, v.step));
        chk("sweep_count_in_sweep", int'(sweep_count), k - 1);
      end
      if (v.extra_start != 0 && (c == 5 || c == 20)) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("final_sweep_count", int'(sweep_count), v.exp_count);
    chk("final_bit_shift", int'(bit_shift), v.exp_shift);
    chk("final_sample", int'(sample), int'(v.exp_sample));
  endtask

  vec_t vecs[5];

  initial begin
    bit seen;
    vecs[0] = '{num: 0,  step: 0, bits: 5'b11111, extra_start: 0,
                exp_shift: 0, exp_count: 0,  exp_sample: 5'b00000};
    vecs[1] = '{num: 3,  step: 0, bits: 5'b01101, extra_start: 0,
                exp_shift: 0, exp_count: 3,  exp_sample: 5'b01101};
    vecs[2] = '{num: 10, step: 2, bits: 5'b00011, extra_start: 0,
                exp_shift: 3, exp_count: 10, exp_sample: 5'b00011};
    vecs[3] = '{num: 2,  step: 1, bits: 5'b10110, extra_start: 1,
                exp_shift: 2, exp_count: 2,  exp_sample: 5'b10110};
    vecs[4] = '{num: 4,  step: 3, bits: 5'b11001, extra_start: 0,
                exp_shift: 1, exp_count: 4,  exp_sample: 5'b11001};

    #1 rst = 1'b1;
    #2;
    chk("reset_update_en", int'(update_en), 0);
    chk("reset_bit_shift", int'(bit_shift), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sample", int'(sample), 0);
    chk("reset_sample_valid", int'(sample_valid), 0);
    chk("reset_sweep_count", int'(sweep_count), 0);
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort in SETTLE after bit 2 of sweep 2 (strobe at c=23).
    num_sweeps = 16'd5; anneal_step = 16'd1; bit_sample = 5'b00111;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 24; c++) tick();
    chk("abort_pre_update_en", int'(update_en), 0);
    chk("abort_pre_busy", int'(busy), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_update_en", int'(update_en), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_sample_valid", int'(sample_valid), 0);
    chk("abort_sweep_count", int'(sweep_count), 1);
    chk("abort_bit_shift_hold", int'(bit_shift), 1);
    chk("abort_sample_hold", int'(sample), 5'b00111);
    for (int c = 0; c < 20; c++) begin
      chk("post_abort_quiet", int'(done | (|update_en)), 0);
      tick();
    end

    // Abort has priority over start in IDLE.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start_busy", int'(busy), 0);
    chk("abort_beats_start_update_en", int'(update_en), 0);

    num_sweeps = 16'd1; anneal_step = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_update_en", int'(update_en), 1);
    chk("restart_bit_shift", int'(bit_shift), 0);
    chk("restart_sweep_count", int'(sweep_count), 0);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("restart_done_seen", int'(seen), 1);
    chk("restart_final_count", int'(sweep_count), 1);
    tick(); tick();

    // Asynchronous reset in the middle of sweep 2.
    num_sweeps = 16'd3; anneal_step = 16'd1; bit_sample = 5'b11111;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("pre_reset_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midreset_update_en", int'(update_en), 0);
    chk("midreset_bit_shift", int'(bit_shift), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_sample", int'(sample), 0);
    chk("midreset_sample_valid", int'(sample_valid), 0);
    chk("midreset_sweep_count", int'(sweep_count), 0);
    #1 rst = 1'b0;
    tick(); tick();
    chk("after_reset_idle_busy", int'(busy), 0);
    chk("after_reset_idle_update_en", int'(update_en), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pbit_sweep_scheduler.md
# pbit_sweep_scheduler

Sequences Gibbs-style sampling sweeps over a fused p-bit network such as an AND, half-adder or full-adder system. It issues one-hot update strobes into the per-p-bit clock/enable vector, so only one p-bit resamples at a time. It also ramps the common `bit_shift` annealing control and captures the network state after every sweep. It sits between the host/test controller and one p-bit system instance.

## Interface

**Parameters**
- `N_BITS`, default 5: number of p-bits sequenced (3 for AND, 4 for HA, 5 for FA).
- `SWEEP_W`, default 16: width of the sweep and anneal counters.
- `SETTLE`, default 2: idle cycles after each strobe, so gate/fusion logic settles before the next update. May be 0.

**Ports**
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  starts a run; sampled only in IDLE.
- `abort`  in  1  terminates the run; has priority over `start`.
- `num_sweeps`  in  SWEEP_W  sweeps per run; latched at start.
- `anneal_step`  in  SWEEP_W  sweeps per `bit_shift` increment; 0 disables annealing. Latched at start.
- `bit_sample`  in  N_BITS  live p-bit outputs of the system.
- `update_en`  out  N_BITS  one-hot update strobe, wired to the system's `clk` vector.
- `bit_shift`  out  2  common bit-shift to all p-bits.
- `busy`  out  1  high in UPDATE, SETTLE and CAPTURE.
- `done`  out  1  one-cycle pulse at normal run completion.
- `sample`  out  N_BITS  state captured at the end of the last completed sweep.
- `sample_valid`  out  1  one-cycle pulse per captured sweep.
- `sweep_count`  out  SWEEP_W  sweeps completed in the current or last run.

## Operation

- **Reset values.** On reset, the state is IDLE and every output is 0: `update_en`, `bit_shift`, `busy`, `done`, `sample`, `sample_valid`, `sweep_count`. The internal bit index and anneal counter are also 0.
- **Registered outputs.** All outputs are registered. `update_en` is decoded from registered state only, so it is glitch-free.
- **States:** IDLE, UPDATE, SETTLE, CAPTURE, DONE.
- **IDLE**
  - On `start` with `abort` low, latch `num_sweeps` and `anneal_step`.
  - Clear the bit index, `sweep_count`, the anneal counter and `bit_shift`.
  - Go to DONE if the latched `num_sweeps` is 0; otherwise go to UPDATE.
- **UPDATE**
  - Lasts one cycle, with `update_en` = 1 << idx.
  - Goes to SETTLE if `SETTLE` > 0; otherwise follows the SETTLE exit rule immediately.
- **SETTLE**
  - Lasts `SETTLE` cycles with `update_en` = 0.
  - Exit: if idx == N_BITS-1, go to CAPTURE; otherwise increment idx and return to UPDATE.
- **CAPTURE** (one cycle)
  - Registers `sample` <= `bit_sample`, pulses `sample_valid` and increments `sweep_count`.
  - Annealing: if `anneal_step` != 0, increment the anneal counter. When it reaches `anneal_step`, clear it and increment `bit_shift`, saturating at 3.
  - If the new `sweep_count` equals `num_sweeps`, go to DONE; otherwise reset idx to 0 and go to UPDATE.
- **DONE**
  - Pulses `done` for one cycle, then returns to IDLE.
  - `bit_shift`, `sample` and `sweep_count` hold their values until the next start.
- **Abort.** `abort` in any non-IDLE state forces IDLE on the next edge.
  - `update_en`, `busy` and `sample_valid` go to 0.
  - No `done` pulse is issued.
  - `sample`, `sweep_count` and `bit_shift` hold.
- **Ignored `start`.** `start` outside IDLE has no effect.
- **Mid-run `reset`.** Clears everything immediately, asynchronously, to the reset values.

## Timing

- Let `start` be sampled at edge t.
  - The first strobe, `update_en[0]`, is high in cycle t+1.
  - Strobes for consecutive bits are spaced 1+SETTLE cycles apart.
- Sweep length L = N_BITS*(1+SETTLE)+1 cycles, including CAPTURE.
- `sample_valid` for sweep k (1-based) occurs in cycle t+k*L. `sample` is updated in that same cycle.
- `done` occurs in cycle t+num_sweeps*L+1. `busy` falls in that same cycle.
- New `bit_shift` is visible from the first UPDATE of the following sweep.
- Zero sweeps: when `num_sweeps` = 0, `done` occurs in cycle t+1 with no strobe.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Test plan

- **Basic run.** N_BITS=5, SETTLE=2, num_sweeps=3, anneal_step=0, start at t.
  - `update_en` = 1,2,4,8,16 at t+1,4,7,10,13; the pattern repeats every 16 cycles.
  - `sample_valid` at t+16, 32, 48; `done` at t+49.
  - `sweep_count` = 3; `bit_shift` stays 0.
- **Annealing.** num_sweeps=10, anneal_step=2.
  - `bit_shift` becomes 1, 2, 3 after sweeps 2, 4, 6.
  - It saturates at 3 through sweeps 8 and 10, and is 3 after `done`.
- **Zero sweeps.** num_sweeps=0: `done` at t+1; `update_en` never asserts; `sweep_count` = 0.
- **Abort.** Abort during SETTLE after bit 2 of sweep 2.
  - Next cycle: `busy` = 0, `update_en` = 0, no `done`, `sweep_count` = 1.
  - A restart begins from `update_en` = 1 with `bit_shift` = 0.
- **Mid-run reset.** `reset` pulsed mid-sweep: all outputs read 0 before the next clock edge.
- **Sample capture and ignored start.** Drive `bit_sample` = 5'b10110 constant with num_sweeps=2.
  - `sample` = 5'b10110 at each `sample_valid`.
  - Extra `start` pulses during the run do not alter the sequence or the `done` time.
